data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
- Two-requester arbiter in front of data_memory: core load/store port (m0) and debug/DMA port (m1).
- Grants one access per cycle with round-robin fairness and optional bounded lock.
- Performs an out-of-range address check.
- Drives data_memory's mem_write/address/write_data and returns registered read data plus a completion strobe to the winner.

Parameters:
- ADDR_W, 32, address width, word-indexed exactly as data_memory.
- DATA_W, 32, data width.
- MEM_DEPTH, 1024, number of valid words; addresses >= MEM_DEPTH are out of range.
- MAX_LOCK, 4, maximum consecutive grants a locking master may hold while the other master is requesting.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  access request, held until m0_gnt.
- m0_we  in  1  1 = write, 0 = read.
- m0_lock  in  1  keep grant on next cycle if still requesting.
- m0_addr  in  ADDR_W  word address.
- m0_wdata  in  DATA_W  write data.
- m0_gnt  out  1  request accepted this cycle (combinational).
- m0_rvalid  out  1  completion strobe, cycle after grant.
- m0_rdata  out  DATA_W  read data, valid with m0_rvalid.
- m0_err  out  1  out-of-range flag, valid with m0_rvalid.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: identical set for m1.
- mem_write  out  1  to data_memory write enable.
- mem_address  out  ADDR_W  to data_memory address.
- mem_write_data  out  DATA_W  to data_memory write data.
- mem_read_data  in  DATA_W  from data_memory read data (combinational read).

Behaviour:
- Reset (async, rst_n=0): last_gnt=1 (m0 wins first contention), lock_cnt=0, rsp_sel/rvalid regs 0, rdata regs 0, err regs 0. Both gnt are forced 0 and mem_write is forced 0 while rst_n=0. mem_address and mem_write_data are 0.
- Grant selection (combinational, each cycle):
  - Only one master requesting: that master wins.
  - Both requesting, lock active (previous winner asserted lock, still requesting, lock_cnt < MAX_LOCK): previous winner wins.
  - Both requesting, otherwise: the master != last_gnt wins.
  - No request: no grant, mem_write=0, mem_address/mem_write_data hold the m0 values (don't-care, but must not write).
- Memory drive: mem_address = winner addr and mem_write_data = winner wdata. mem_write = winner we AND (addr < MEM_DEPTH).
- Out-of-range writes are dropped silently, apart from the err flag.
- At posedge with a grant:
  - last_gnt <= winner.
  - lock_cnt <= (winner == last_gnt and both requesting) ? lock_cnt+1 : 0.
  - Response regs capture rdata = (read and in range) ? mem_read_data : 0; err = (addr >= MEM_DEPTH).
- Response: winner's rvalid=1 for exactly one cycle after the grant cycle (latency 1), for both reads and writes. The other master's rvalid=0. rdata/err hold their last values when rvalid=0.
- Back-to-back: a master may be granted every cycle. rvalid then stays high continuously, with rdata updating each cycle.
- Read-after-write same address, consecutive grants: the read sees the new data (write commits at the grant edge, read occurs in the next cycle).
- Lock bound: after MAX_LOCK consecutive locked grants with the other master waiting, the lock is ignored for one arbitration and the other master wins. lock_cnt resets to 0.
- Lock with no contender: grants continue, and lock_cnt does not increment.
- Reset mid-operation: a pending rvalid is cleared immediately (async). Any in-flight write at that edge is not performed because mem_write is forced 0.
- Requests must stay stable while req=1 and gnt=0. Changing them is a protocol violation and is not checked.

Test Plan:
- Reset then m0 read addr 1 (never written) -> m0_gnt same cycle; next cycle m0_rvalid=1, m0_rdata=0, m0_err=0, m1_rvalid=0.
- m0 write addr 2 data 50, then m1 read addr 2 -> m1_rvalid cycle after its grant with m1_rdata=0x00000032.
- Both request every cycle, no lock, m0 addr 10 / m1 addr 11 -> grants alternate m0,m1,m0,m1 starting with m0 after reset; each rvalid pulses on alternate cycles.
- Both request continuously, m1 lock=1, m1 already granted -> m1 granted 4 more consecutive times (MAX_LOCK), then m0 granted once, lock_cnt back to 0.
- m1 write addr 1023 data 0xFFFFFFFF, then read 1023 -> rdata 0xFFFFFFFF, err=0. Write addr 1024 data 0x12345678 -> mem_write=0, err=1. Read 1024 -> rdata 0, err=1; memory word 0 unchanged.
- m0 read granted, rst_n pulled low before next edge -> m0_rvalid=0 immediately, gnt=0 and mem_write=0 while low; after release, first contention goes to m0.

Source files
------------

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester-side access port of the data memory arbiter
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter with bounded lock in front of data_memory
module data_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int MAX_LOCK  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_arbiter_if.slave    m0,
    data_mem_arbiter_if.slave    m1,
    output logic                 mem_write,
    output logic [ADDR_W-1:0]    mem_address,
    output logic [DATA_W-1:0]    mem_write_data,
    input  logic [DATA_W-1:0]    mem_read_data
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic              last_gnt;
    logic [CNT_W-1:0]  lock_cnt;
    logic              both_req;
    logic              lock_hold;
    logic              winner;
    logic              grant;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rsp_data;
    logic              rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err0, err1;

    assign both_req  = m0.req && m1.req;
    // The lock belongs to whoever won last; it only matters while the other side is waiting.
    assign lock_hold = both_req && (last_gnt ? m1.lock : m0.lock)
                       && (lock_cnt < CNT_W'(MAX_LOCK));

    always_comb begin
        winner = 1'b0;
        if (m1.req && !m0.req)
            winner = 1'b1;
        else if (both_req)
            winner = lock_hold ? last_gnt : ~last_gnt;
    end

    assign grant     = rst_n && (m0.req || m1.req);
    assign win_we    = winner ? m1.we    : m0.we;
    assign win_addr  = winner ? m1.addr  : m0.addr;
    assign win_wdata = winner ? m1.wdata : m0.wdata;
    assign in_range  = {1'b0, win_addr} < (ADDR_W + 1)'(MEM_DEPTH);
    assign rsp_data  = (!win_we && in_range) ? mem_read_data : '0;

    assign m0.gnt         = grant && !winner;
    assign m1.gnt         = grant && winner;
    assign mem_write      = grant && win_we && in_range;
    assign mem_address    = rst_n ? win_addr  : '0;
    assign mem_write_data = rst_n ? win_wdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= 1'b1;
            lock_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
            err0     <= 1'b0;
            err1     <= 1'b0;
        end else begin
            rvalid0 <= grant && !winner;
            rvalid1 <= grant && winner;
            if (grant) begin
                last_gnt <= winner;
                lock_cnt <= (both_req && (winner == last_gnt)) ? lock_cnt + CNT_W'(1) : '0;
            end
            if (grant && !winner) begin
                rdata0 <= rsp_data;
                err0   <= !in_range;
            end
            if (grant && winner) begin
                rdata1 <= rsp_data;
                err1   <= !in_range;
            end
        end
    end

    assign m0.rvalid = rvalid0;
    assign m0.rdata  = rdata0;
    assign m0.err    = err0;
    assign m1.rvalid = rvalid1;
    assign m1.rdata  = rdata1;
    assign m1.err    = err1;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
    logic        clk;
    logic        rst_n;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    data_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

    data_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(1024), .MAX_LOCK(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0             (m0_if.slave),
        .m1             (m1_if.slave),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    // Backing store is deeper than MEM_DEPTH so a leaked out-of-range write would land somewhere visible.
    logic [31:0] mem [0:2047] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023] = '{default: 32'h0};

    assign mem_read_data = mem[mem_address[10:0]];
    always @(posedge clk) if (mem_write) mem[mem_address[10:0]] <= mem_write_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int m, input logic req, input logic we, input logic lock,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.lock = lock; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.lock = lock; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    // Called at a negedge with inputs set; exp_g = expected winner (-1 none). Returns at the next negedge.
    task automatic step(input int exp_g);
        logic [31:0] a, wd;
        logic        we, in_r;
        rsp_t        e;
        #1;
        check("m0_gnt", m0_if.gnt, exp_g == 0);
        check("m1_gnt", m1_if.gnt, exp_g == 1);
        if (exp_g >= 0) begin
            a    = (exp_g == 1) ? m1_if.addr  : m0_if.addr;
            wd   = (exp_g == 1) ? m1_if.wdata : m0_if.wdata;
            we   = (exp_g == 1) ? m1_if.we    : m0_if.we;
            in_r = a < 32'd1024;
            check("mem_write", mem_write, we && in_r);
            check("mem_address", mem_address, a);
            e.m     = exp_g;
            e.rdata = (!we && in_r) ? ref_mem[a[9:0]] : 32'h0;
            e.err   = !in_r;
            exp_q.push_back(e);
            if (we && in_r) ref_mem[a[9:0]] = wd;
        end else begin
            check("mem_write_idle", mem_write, 1'b0);
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rvalid_winner", (e.m == 1) ? m1_if.rvalid : m0_if.rvalid, 1'b1);
            check("rvalid_other",  (e.m == 1) ? m0_if.rvalid : m1_if.rvalid, 1'b0);
            check("rdata", (e.m == 1) ? m1_if.rdata : m0_if.rdata, e.rdata);
            check("err",   (e.m == 1) ? m1_if.err   : m0_if.err,   e.err);
        end else begin
            check("m0_rvalid_idle", m0_if.rvalid, 1'b0);
            check("m1_rvalid_idle", m1_if.rvalid, 1'b0);
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b0, 32'd3, 32'hDEAD_BEEF);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_m0_gnt", m0_if.gnt, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_m0_rvalid", m0_if.rvalid, 1'b0);
        check("rst_m1_rvalid", m1_if.rvalid, 1'b0);
        check("rst_m0_rdata", m0_if.rdata, 32'd0);
        check("rst_m1_err", m1_if.err, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;

        // Single read of a never-written word.
        drive(0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0);
        step(0);

        // Write then cross-port read.
        drive(0, 1'b1, 1'b1, 1'b0, 32'd2, 32'd50);
        step(0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
        step(1);
        check("m1_rdata_0x32", m1_if.rdata, 32'h32);

        // Round-robin alternation from reset.
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        pulse_reset();
        drive(0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd0);
        for (int i = 0; i < 4; i++) step(i % 2);

        // Bounded lock held by m1, then round-robin resumes.
        m1_if.lock = 1'b1;
        for (int i = 0; i < 4; i++) step(1);
        step(0);
        step(1);

        // Lock with no contender must not consume the budget.
        m0_if.req = 1'b0;
        for (int i = 0; i < 3; i++) step(1);
        m0_if.req = 1'b1;
        for (int i = 0; i < 4; i++) step(1);
        step(0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(-1);

        // Range edges.
        drive(1, 1'b1, 1'b1, 1'b0, 32'd1023, 32'hFFFF_FFFF);
        step(1);
        drive(1, 1'b1, 1'b0, 1'b0, 32'd1023, 32'd0);
        step(1);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(-1);
        check("m1_rdata_hold", m1_if.rdata, 32'hFFFF_FFFF);
        drive(1, 1'b1, 1'b1, 1'b0, 32'd1024, 32'h1234_5678);
        step(1);
        drive(1, 1'b1, 1'b0, 1'b0, 32'd1024, 32'd0);
        step(1);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        check("mem_word0", mem[0], 32'd0);
        check("mem_word1024", mem[1024], 32'd0);

        // Asynchronous reset with a response pending and a write in flight.
        drive(0, 1'b1, 1'b0, 1'b0, 32'd2, 32'd0);
        step(0);
        drive(0, 1'b1, 1'b1, 1'b0, 32'd5, 32'h0000_00AA);
        #1;
        check("pre_rst_m0_rvalid", m0_if.rvalid, 1'b1);
        check("pre_rst_mem_write", mem_write, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_m0_rvalid", m0_if.rvalid, 1'b0);
        check("async_m0_gnt", m0_if.gnt, 1'b0);
        check("async_mem_write", mem_write, 1'b0);
        check("async_m0_rdata", m0_if.rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("mem_word5", mem[5], 32'd0);
        drive(0, 1'b1, 1'b0, 1'b0, 32'd10, 32'd0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'd11, 32'd0);
        rst_n = 1'b1;
        step(0);
        step(1);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        step(-1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
